life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
- Parametrised Conway Game-of-Life engine for an arbitrary ROWS x COLS grid, with a selectable dead-boundary or toroidal edge mode.
- Cells are loaded serially, one bit per accepted beat, in row-major order.
- Each generation is computed in parallel in one cycle. The grid is then streamed out with a valid/ready handshake, tagged with cell index.
- Supports single-step and free-run modes, a generation counter, still-life detection and a live-cell count. It sits between the input-switch decoder and the display/serial output logic.

Parameters:
- ROWS, 8, grid rows (>=3)
- COLS, 8, grid columns (>=3)
- WRAP, 0, 0 = cells outside the grid count as dead; 1 = toroidal, indices taken modulo ROWS/COLS
- GEN_W, 8, width of the generation counter
- (derived) N = ROWS*COLS; IDX_W = clog2(N); CNT_W = clog2(N+1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- load_start  in  1  IDLE-only request to begin loading a new grid
- load_valid  in  1  load_bit is valid this cycle (LOAD state only)
- load_bit  in  1  cell value; 1 = alive
- load_ready  out  1  high in LOAD; a beat transfers when load_valid & load_ready
- step  in  1  IDLE-only request to compute exactly one generation
- run  in  1  level; while high, generations repeat back-to-back
- out_valid  out  1  out_bit/out_idx valid
- out_ready  in  1  consumer accepts the beat when out_valid & out_ready
- out_bit  out  1  cell value
- out_idx  out  IDX_W  cell index = r*COLS + c
- gen_count  out  GEN_W  generations computed since reset or last load
- live_count  out  CNT_W  live cells in the current grid, valid after each dump
- stable  out  1  last computed generation equalled its predecessor
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on return to IDLE after a dump

Behaviour:
- Reset (synchronous, active-high), effective at the next edge and overriding everything including mid-LOAD/mid-DUMP:
  - grid = all 0; state = IDLE
  - gen_count, live_count, out_idx = 0
  - out_valid, load_ready, stable, busy, done = 0
- Rule B3/S23:
  - a live cell survives with 2 or 3 live neighbours
  - a dead cell is born with exactly 3 live neighbours
  - all other cells become dead
- WRAP=0: missing neighbours count 0. WRAP=1: row -1 is row ROWS-1, col -1 is col COLS-1, and so on.
- State IDLE:
  - load_start -> LOAD (load_start has priority when asserted together with step or run)
  - otherwise step | run -> COMPUTE
  - step and load_start are ignored in every other state; they are not queued
- State LOAD:
  - load_ready = 1; each accepted beat writes cell idx 0,1,...,N-1 in order
  - after beat N-1 -> IDLE; gen_count <= 0; stable <= 0
  - stalls (load_valid = 0) allowed indefinitely; no timeout
- State COMPUTE, exactly 1 cycle:
  - all N cells <= next state
  - stable <= (next grid == current grid)
  - gen_count <= gen_count + 1, wrapping modulo 2^GEN_W
  - -> DUMP with out_idx = 0
- State DUMP:
  - out_valid = 1; out_bit = grid[out_idx]
  - on each handshake, out_idx increments and a live-cell accumulator adds out_bit
  - with out_ready = 0: out_bit, out_idx and out_valid hold
  - on the handshake of idx N-1: live_count <= accumulated total
  - exit: if run & ~stable -> COMPUTE; else -> IDLE with done = 1 for one cycle and out_valid = 0
- Minimum period with out_ready held high: N+1 cycles per generation in run mode.
- No combinational path from out_ready or load_valid to any output.

Test Plan:
- 8x8, WRAP=0: load vertical blinker at idx 11,19,27 and pulse step -> dump live at idx 18,19,20 only; gen_count=1, live_count=3, stable=0. Second step -> idx 11,19,27 again.
- 8x8, WRAP=0 vs WRAP=1: load idx 0,7,56 and step.
  - WRAP=0 -> all three die; live_count=0.
  - WRAP=1 -> idx 0,7,56 survive and 63 is born; live_count=4. A further step gives stable=1.
- 8x8, WRAP=1: load glider at idx 1,10,16,17,18 and hold run for 32 generations -> grid identical to the initial load; gen_count=32.
- Load 2x2 block at idx 27,28,35,36 with run held high -> after the first generation stable=1, engine returns to IDLE, done pulses once, gen_count=1.
- Backpressure: toggle out_ready 1/0 every cycle during DUMP -> out_idx sequence 0..63 without skips or duplicates; out_idx/out_bit stable while stalled; dump takes 127 cycles.
- Assert reset at DUMP idx 20 -> next cycle: state IDLE, out_valid=0, gen_count=0, grid all 0. A following step dumps 64 zeros.

Source files
------------

// File: rtl/life_engine.sv
// Game-of-Life engine: serial row-major load, one-cycle parallel generation, indexed valid/ready dump.
// Latency: 1 compute cycle + N dump beats per generation; out_ready low freezes the dump, load_valid low stalls the load.
module life_engine #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int WRAP  = 0,
    parameter int GEN_W = 8,
    localparam int N     = ROWS * COLS,
    localparam int IDX_W = $clog2(N),
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic             load_bit,
    output logic             load_ready,
    input  logic             step,
    input  logic             run,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [IDX_W-1:0] out_idx,
    output logic [GEN_W-1:0] gen_count,
    output logic [CNT_W-1:0] live_count,
    output logic             stable,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DUMP} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           state, state_nxt;
    logic [N-1:0]     grid, grid_nxt;
    logic [IDX_W-1:0] load_idx;
    logic [CNT_W-1:0] acc;
    logic             accept, fire, last_load, last_out;
    int               nr, nc;
    logic             in_grid;
    logic [3:0]       nbr;

    assign load_ready = (state == LOAD);
    assign out_valid  = (state == DUMP);
    assign busy       = (state != IDLE);
    assign out_bit    = grid[out_idx];
    assign accept     = load_valid & load_ready;
    assign fire       = out_valid & out_ready;
    assign last_load  = (load_idx == LAST);
    assign last_out   = (out_idx == LAST);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start)      state_nxt = LOAD;
                else if (step | run) state_nxt = COMPUTE;
            end
            LOAD:    if (accept && last_load) state_nxt = IDLE;
            COMPUTE: state_nxt = DUMP;
            DUMP: begin
                if (fire && last_out) state_nxt = (run && !stable) ? COMPUTE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Neighbour count per cell; off-grid neighbours are dead unless the grid wraps.
    always_comb begin
        grid_nxt = '0;
        nr       = 0;
        nc       = 0;
        in_grid  = 1'b0;
        nbr      = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                nbr = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            nr = r + dr;
                            nc = c + dc;
                            if (WRAP != 0) begin
                                nr      = (nr + ROWS) % ROWS;
                                nc      = (nc + COLS) % COLS;
                                in_grid = 1'b1;
                            end else begin
                                in_grid = (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
                            end
                            if (in_grid && grid[IDX_W'(nr * COLS + nc)]) nbr = nbr + 4'd1;
                        end
                    end
                end
                grid_nxt[IDX_W'(r * COLS + c)] = (nbr == 4'd3) ||
                                                 ((nbr == 4'd2) && grid[IDX_W'(r * COLS + c)]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grid       <= '0;
            gen_count  <= '0;
            live_count <= '0;
            out_idx    <= '0;
            load_idx   <= '0;
            acc        <= '0;
            stable     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (load_start) load_idx <= '0;
                LOAD: begin
                    if (accept) begin
                        grid[load_idx] <= load_bit;
                        load_idx       <= load_idx + IDX_W'(1);
                        if (last_load) begin
                            gen_count <= '0;
                            stable    <= 1'b0;
                        end
                    end
                end
                COMPUTE: begin
                    grid      <= grid_nxt;
                    stable    <= (grid_nxt == grid);
                    gen_count <= gen_count + GEN_W'(1);
                    out_idx   <= '0;
                    acc       <= '0;
                end
                DUMP: begin
                    if (fire) begin
                        acc <= acc + CNT_W'(out_bit);
                        if (last_out) begin
                            live_count <= acc + CNT_W'(out_bit);
                            done       <= !(run && !stable);
                        end else begin
                            out_idx <= out_idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: two 8x8 instances (dead edge and torus) share all inputs.
module tb_life_engine;
    localparam int N = 64;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1, load_start = 1'b0, load_valid = 1'b0, load_bit = 1'b0;
    logic step = 1'b0, run = 1'b0, out_ready = 1'b1;
    logic lr0, lr1, v0, v1, b0, b1, st0, st1, bz0, bz1, d0, d1;
    logic [5:0] i0, i1;
    logic [7:0] g0, g1;
    logic [6:0] lc0, lc1;

    life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(8)) dut0 (
        .clock(clock), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_bit(load_bit), .load_ready(lr0), .step(step), .run(run), .out_valid(v0),
        .out_ready(out_ready), .out_bit(b0), .out_idx(i0), .gen_count(g0),
        .live_count(lc0), .stable(st0), .busy(bz0), .done(d0));

    life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(8)) dut1 (
        .clock(clock), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_bit(load_bit), .load_ready(lr1), .step(step), .run(run), .out_valid(v1),
        .out_ready(out_ready), .out_bit(b1), .out_idx(i1), .gen_count(g1),
        .live_count(lc1), .stable(st1), .busy(bz1), .done(d1));

    int checks = 0;
    int fails  = 0;
    logic [6:0] exp0_q[$], exp1_q[$], obs0_q[$], obs1_q[$];  // {bit, idx}
    int dump_cycles, stall_changes;
    bit timed_out;

    function automatic logic [63:0] life_model(input logic [63:0] g, input bit wrap);
        logic [63:0] nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
                            continue;
                        end
                        if (g[6'(rr * 8 + cc)]) n++;
                    end
                end
                if (g[6'(r * 8 + c)]) nx[6'(r * 8 + c)] = (n == 2 || n == 3);
                else                  nx[6'(r * 8 + c)] = (n == 3);
            end
        end
        return nx;
    endfunction

    function automatic logic [63:0] cells3(input int a, input int b, input int c);
        logic [63:0] g = '0;
        g[6'(a)] = 1'b1;
        g[6'(b)] = 1'b1;
        g[6'(c)] = 1'b1;
        return g;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
        step = 1'b0; run = 1'b0; out_ready = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_grid(input logic [63:0] g);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < N;) begin
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                load_bit   = 1'($urandom);
            end else begin
                load_valid = 1'b1;
                load_bit   = g[6'(i)];
                i++;
            end
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic push_exp(input bit which, input logic [63:0] g);
        for (int i = 0; i < N; i++) begin
            if (which) exp1_q.push_back({g[6'(i)], 6'(i)});
            else       exp0_q.push_back({g[6'(i)], 6'(i)});
        end
    endtask

    task automatic pulse_step;
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    // Collects one dump of instance sel (and whatever the other instance hands over meanwhile).
    task automatic capture(input bit sel, input bit toggle, input bit drop_run);
        int cyc = 0;
        int beats = 0;
        bit held = 1'b0;
        logic [5:0] hidx = '0;
        logic hbit = 1'b0;
        logic vld, bv;
        logic [5:0] iv;
        obs0_q.delete(); obs1_q.delete();
        dump_cycles = 0; stall_changes = 0; timed_out = 1'b0;
        while (beats < N && cyc < 400) begin
            vld = sel ? v1 : v0;
            bv  = sel ? b1 : b0;
            iv  = sel ? i1 : i0;
            if (vld) begin
                if (held && (iv !== hidx || bv !== hbit)) stall_changes++;
                out_ready = toggle ? (dump_cycles % 2 == 0) : 1'b1;
                if (drop_run && beats == N - 1 && out_ready) run = 1'b0;
                dump_cycles++;
                if (out_ready) begin
                    beats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; hidx = iv; hbit = bv;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (v0 && out_ready) obs0_q.push_back({b0, i0});
            if (v1 && out_ready) obs1_q.push_back({b1, i1});
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        if (beats < N) timed_out = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (v0 !== 1'b0)  begin fails++; $display("FAIL reset_out_valid: got %b want 0", v0); end
        checks++; if (lr0 !== 1'b0) begin fails++; $display("FAIL reset_load_ready: got %b want 0", lr0); end
        checks++; if (bz0 !== 1'b0 || bz1 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b/%b want 0/0", bz0, bz1); end
        checks++; if (d0 !== 1'b0)  begin fails++; $display("FAIL reset_done: got %b want 0", d0); end
        checks++; if (g0 !== 8'd0)  begin fails++; $display("FAIL reset_gen: got %0d want 0", g0); end
        checks++; if (lc0 !== 7'd0) begin fails++; $display("FAIL reset_live: got %0d want 0", lc0); end
        checks++; if (st0 !== 1'b0) begin fails++; $display("FAIL reset_stable: got %b want 0", st0); end
        checks++; if (i0 !== 6'd0)  begin fails++; $display("FAIL reset_idx: got %0d want 0", i0); end
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++; if (lr0 !== 1'b1 || bz0 !== 1'b1) begin fails++; $display("FAIL load_entry: got ready=%b busy=%b want 1/1", lr0, bz0); end
        do_reset();
        checks++; if (lr0 !== 1'b0 || lr1 !== 1'b0) begin fails++; $display("FAIL reset_mid_load: got ready=%b/%b want 0/0", lr0, lr1); end
    endtask

    task automatic test_blinker;
        logic [63:0] vert = cells3(11, 19, 27);
        logic [6:0] e, o;
        do_reset();
        load_grid(vert);
        for (int s = 1; s <= 2; s++) begin
            push_exp(1'b0, (s == 1) ? cells3(18, 19, 20) : vert);
            pulse_step();
            capture(1'b0, 1'b0, 1'b0);
            checks++; if (timed_out) begin fails++; $display("FAIL blinker_timeout: dump %0d incomplete", s); end
            while (exp0_q.size() > 0) begin
                e = exp0_q.pop_front();
                if (obs0_q.size() == 0) o = 7'bx; else o = obs0_q.pop_front();
                checks++;
                if (o !== e) begin fails++; $display("FAIL blinker_beat: got bit=%b idx=%0d want bit=%b idx=%0d", o[6], o[5:0], e[6], e[5:0]); end
            end
            checks++; if (g0 !== 8'(s)) begin fails++; $display("FAIL blinker_gen: got %0d want %0d", g0, s); end
            checks++; if (lc0 !== 7'd3) begin fails++; $display("FAIL blinker_live: got %0d want 3", lc0); end
            checks++; if (st0 !== 1'b0) begin fails++; $display("FAIL blinker_stable: got %b want 0", st0); end
            checks++; if (d0 !== 1'b1) begin fails++; $display("FAIL blinker_done: got %b want 1", d0); end
            tick();
            checks++; if (d0 !== 1'b0 || bz0 !== 1'b0) begin fails++; $display("FAIL blinker_idle: got done=%b busy=%b want 0/0", d0, bz0); end
        end
    endtask

    task automatic test_wrap;
        logic [63:0] corners = cells3(0, 7, 56);
        logic [63:0] blk = corners;
        logic [6:0] e, o;
        blk[63] = 1'b1;
        do_reset();
        load_grid(corners);
        for (int s = 1; s <= 2; s++) begin
            push_exp(1'b0, 64'd0);
            push_exp(1'b1, blk);
            pulse_step();
            capture(1'b1, 1'b0, 1'b0);
            checks++; if (timed_out) begin fails++; $display("FAIL wrap_timeout: dump %0d incomplete", s); end
            while (exp0_q.size() > 0) begin
                e = exp0_q.pop_front();
                if (obs0_q.size() == 0) o = 7'bx; else o = obs0_q.pop_front();
                checks++;
                if (o !== e) begin fails++; $display("FAIL wrap0_beat: got bit=%b idx=%0d want bit=%b idx=%0d", o[6], o[5:0], e[6], e[5:0]); end
            end
            while (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                if (obs1_q.size() == 0) o = 7'bx; else o = obs1_q.pop_front();
                checks++;
                if (o !== e) begin fails++; $display("FAIL wrap1_beat: got bit=%b idx=%0d want bit=%b idx=%0d", o[6], o[5:0], e[6], e[5:0]); end
            end
            checks++; if (lc0 !== 7'd0) begin fails++; $display("FAIL wrap0_live: got %0d want 0", lc0); end
            checks++; if (lc1 !== 7'd4) begin fails++; $display("FAIL wrap1_live: got %0d want 4", lc1); end
            checks++; if (st1 !== (s == 2)) begin fails++; $display("FAIL wrap1_stable: got %b want %b", st1, (s == 2)); end
            checks++; if (g1 !== 8'(s)) begin fails++; $display("FAIL wrap1_gen: got %0d want %0d", g1, s); end
        end
        checks++; if (st0 !== 1'b1) begin fails++; $display("FAIL wrap0_stable: got %b want 1", st0); end
    endtask

    task automatic test_glider;
        logic [63:0] glider = cells3(1, 10, 16);
        logic [63:0] cur;
        logic [6:0] e, o;
        glider[17] = 1'b1;
        glider[18] = 1'b1;
        cur = glider;
        do_reset();
        load_grid(glider);
        run = 1'b1;
        for (int gen = 1; gen <= 32; gen++) begin
            cur = life_model(cur, 1'b1);
            push_exp(1'b1, (gen == 32) ? glider : cur);
            capture(1'b1, 1'b0, gen == 32);
            checks++; if (timed_out) begin fails++; $display("FAIL glider_timeout: generation %0d", gen); end
            while (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                if (obs1_q.size() == 0) o = 7'bx; else o = obs1_q.pop_front();
                checks++;
                if (o !== e) begin fails++; $display("FAIL glider_beat: gen %0d got bit=%b idx=%0d want bit=%b idx=%0d", gen, o[6], o[5:0], e[6], e[5:0]); end
            end
        end
        checks++; if (g1 !== 8'd32) begin fails++; $display("FAIL glider_gen: got %0d want 32", g1); end
        checks++; if (lc1 !== 7'd5) begin fails++; $display("FAIL glider_live: got %0d want 5", lc1); end
        checks++; if (d1 !== 1'b1) begin fails++; $display("FAIL glider_done: got %b want 1", d1); end
    endtask

    task automatic test_block_run;
        logic [63:0] blk = cells3(27, 28, 35);
        logic [6:0] e, o;
        int pulses = 0;
        blk[36] = 1'b1;
        do_reset();
        load_grid(blk);
        push_exp(1'b0, blk);
        run = 1'b1;
        capture(1'b0, 1'b0, 1'b0);
        checks++; if (timed_out) begin fails++; $display("FAIL block_timeout: dump incomplete"); end
        while (exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            if (obs0_q.size() == 0) o = 7'bx; else o = obs0_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL block_beat: got bit=%b idx=%0d want bit=%b idx=%0d", o[6], o[5:0], e[6], e[5:0]); end
        end
        checks++; if (st0 !== 1'b1) begin fails++; $display("FAIL block_stable: got %b want 1", st0); end
        checks++; if (lc0 !== 7'd4) begin fails++; $display("FAIL block_live: got %0d want 4", lc0); end
        if (d0 === 1'b1) pulses++;
        run = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (d0 === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin fails++; $display("FAIL block_done_pulses: got %0d want 1", pulses); end
        checks++; if (g0 !== 8'd1) begin fails++; $display("FAIL block_gen: got %0d want 1", g0); end
        checks++; if (bz0 !== 1'b0 || v0 !== 1'b0) begin fails++; $display("FAIL block_idle: got busy=%b valid=%b want 0/0", bz0, v0); end
    endtask

    task automatic test_backpressure;
        logic [63:0] g = {$urandom, $urandom};
        logic [63:0] n0 = life_model(g, 1'b0);
        logic [6:0] e, o;
        do_reset();
        load_grid(g);
        push_exp(1'b0, n0);
        push_exp(1'b1, life_model(g, 1'b1));
        pulse_step();
        capture(1'b0, 1'b1, 1'b0);
        checks++; if (timed_out) begin fails++; $display("FAIL bp_timeout: dump incomplete"); end
        while (exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            if (obs0_q.size() == 0) o = 7'bx; else o = obs0_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL bp0_beat: got bit=%b idx=%0d want bit=%b idx=%0d", o[6], o[5:0], e[6], e[5:0]); end
        end
        while (exp1_q.size() > 0) begin
            e = exp1_q.pop_front();
            if (obs1_q.size() == 0) o = 7'bx; else o = obs1_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL bp1_beat: got bit=%b idx=%0d want bit=%b idx=%0d", o[6], o[5:0], e[6], e[5:0]); end
        end
        checks++; if (dump_cycles != 127) begin fails++; $display("FAIL bp_cycles: got %0d want 127", dump_cycles); end
        checks++; if (stall_changes != 0) begin fails++; $display("FAIL bp_stall_hold: got %0d changes want 0", stall_changes); end
        checks++; if (lc0 !== 7'($countones(n0))) begin fails++; $display("FAIL bp_live: got %0d want %0d", lc0, $countones(n0)); end
    endtask

    task automatic test_reset_mid_dump;
        logic [6:0] e, o;
        bit found = 1'b0;
        do_reset();
        load_grid({$urandom, $urandom} | 64'h0000_0000_0038_0000);
        pulse_step();
        out_ready = 1'b1;
        for (int k = 0; k < 200 && !found; k++) begin
            if (v0 && i0 == 6'd20) found = 1'b1;
            else tick();
        end
        checks++; if (!found) begin fails++; $display("FAIL rst_dump_reach: idx 20 not reached"); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (v0 !== 1'b0 || bz0 !== 1'b0) begin fails++; $display("FAIL rst_dump_state: got valid=%b busy=%b want 0/0", v0, bz0); end
        checks++; if (g0 !== 8'd0) begin fails++; $display("FAIL rst_dump_gen: got %0d want 0", g0); end
        checks++; if (i0 !== 6'd0) begin fails++; $display("FAIL rst_dump_idx: got %0d want 0", i0); end
        push_exp(1'b0, 64'd0);
        pulse_step();
        capture(1'b0, 1'b0, 1'b0);
        checks++; if (timed_out) begin fails++; $display("FAIL rst_dump_timeout: dump incomplete"); end
        while (exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            if (obs0_q.size() == 0) o = 7'bx; else o = obs0_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL rst_dump_beat: got bit=%b idx=%0d want bit=%b idx=%0d", o[6], o[5:0], e[6], e[5:0]); end
        end
        checks++; if (g0 !== 8'd1 || lc0 !== 7'd0) begin fails++; $display("FAIL rst_dump_counts: got gen=%0d live=%0d want 1/0", g0, lc0); end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_wrap();
        test_glider();
        test_block_run();
        test_backpressure();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
